// File: rtl/uart_txq_pkg.sv
// Shared types and constants for the UART transmit word queue.
// Status struct packs the CPU-visible queue state for register readback.
package uart_txq_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned DROP_W         = 8;
    localparam int unsigned STATUS_LEVEL_W = 8;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_BOTH
    } txq_op_t;

    typedef struct packed {
        logic                      full;
        logic                      empty;
        logic                      overflow;
        logic [STATUS_LEVEL_W-1:0] level;
    } txq_status_t;

    function automatic txq_op_t txq_op(input logic push, input logic pop);
        if (push && pop) return OP_BOTH;
        if (push)        return OP_PUSH;
        if (pop)         return OP_POP;
        return OP_IDLE;
    endfunction

endpackage

// File: rtl/uart_txq_ram.sv
// DEPTH x DATA_W storage for the transmit queue: synchronous write, asynchronous read.
// Contents are cleared on reset so the head output is defined before the first store.
module uart_txq_ram
    import uart_txq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_word_queue.sv
// Word FIFO between CPU UART stores and the transmit parser, show-ahead valid/ready output.
// Overflow accounting (sticky flag + saturating drop counter) enabled by UART_TXQ_OVF_EN.
module uart_tx_word_queue
    import uart_txq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     memwrite,
    input  logic [DATA_W-1:0]        writedata,
    input  logic                     flush,
    output logic                     word_valid,
    output logic [DATA_W-1:0]        word_data,
    input  logic                     word_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop, drop;

    assign empty      = (level_q == '0);
    assign full       = (level_q == LW'(DEPTH));
    assign level      = level_q;
    assign word_valid = !empty;

    // A pop frees a slot in the same cycle, so a full queue still accepts a store.
    assign pop  = word_valid && word_ready;
    assign push = memwrite && (!full || pop);
    assign drop = memwrite && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case (txq_op(push, pop))
                OP_PUSH: level_d = level_q + 1'b1;
                OP_POP:  level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    uart_txq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .we_i    (push && !flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (writedata),
        .raddr_i (rd_ptr_q),
        .rdata_o (word_data)
    );

`ifdef UART_TXQ_OVF_EN
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] cnt_q, cnt_d;

    // A drop coinciding with a clear restarts the count at one.
    always_comb begin
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (drop && !flush) begin
            ovf_d = 1'b1;
            if (ovf_clr)          cnt_d = DROP_W'(1);
            else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign overflow   = ovf_q;
    assign drop_count = cnt_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr ^ drop;
    assign overflow   = 1'b0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_uart_tx_word_queue.sv
// Self-checking bench for uart_tx_word_queue: scoreboard of accepted words plus a
// behavioural level/overflow model, checked per scenario task.
module tb_uart_tx_word_queue;
    import uart_txq_pkg::*;

    localparam int DEPTH = 8;

    logic              clk;
    logic              reset_n;
    logic              memwrite;
    logic [DATA_W-1:0] writedata;
    logic              flush;
    logic              word_valid;
    logic [DATA_W-1:0] word_data;
    logic              word_ready;
    logic              full;
    logic              empty;
    logic [3:0]        level;
    logic              overflow;
    logic              ovf_clr;
    logic [7:0]        drop_count;

    uart_tx_word_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .memwrite   (memwrite),
        .writedata  (writedata),
        .flush      (flush),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] sb[$];
    int          m_lvl;
    bit          m_ovf;
    int          m_cnt;
    int          n_pass;
    int          n_total;

    logic [15:0] obs_status;
    assign obs_status = {word_valid, full, empty, level, overflow, drop_count};

    function automatic logic [15:0] m_status();
        return {m_lvl != 0, m_lvl == DEPTH, m_lvl == 0, 4'(m_lvl), m_ovf, 8'(m_cnt)};
    endfunction

    // Reference model advanced on the falling edge, using inputs held for the next rising edge.
    always @(negedge clk) begin
        bit          mpop, mpush, mdrop;
        logic [31:0] exp_w;
        if (reset_n) begin
            mpop  = (m_lvl > 0) && word_ready;
            mpush = memwrite && ((m_lvl < DEPTH) || mpop);
            mdrop = memwrite && (m_lvl == DEPTH) && !mpop;
            if (flush) begin
                sb.delete();
                m_lvl = 0;
            end else begin
                if (mpop) begin
                    n_total++;
                    if (sb.size() == 0) begin
                        $display("FAIL pop_data: pop with empty scoreboard, got %h", word_data);
                    end else begin
                        exp_w = sb.pop_front();
                        if (word_valid !== 1'b1 || word_data !== exp_w)
                            $display("FAIL pop_data: got valid=%b data=%h, expected valid=1 data=%h",
                                     word_valid, word_data, exp_w);
                        else
                            n_pass++;
                    end
                end
                if (mpush) sb.push_back(writedata);
                m_lvl = m_lvl + int'(mpush) - int'(mpop);
            end
`ifdef UART_TXQ_OVF_EN
            if (mdrop && !flush) begin
                m_ovf = 1'b1;
                m_cnt = ovf_clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
`else
            if (mdrop || ovf_clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            memwrite  = 1'b1;
            writedata = base + 32'(i);
            cyc();
        end
        memwrite = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        word_ready = 1'b1;
        while (empty !== 1'b1 && k < 40) begin
            cyc();
            k++;
        end
        word_ready = 1'b0;
        n_total++;
        if (empty !== 1'b1 || sb.size() != 0)
            $display("FAIL %s_drain: empty=%b leftover=%0d after %0d cycles, expected empty=1 leftover=0",
                     name, empty, sb.size(), k);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; memwrite = 1'b0; writedata = '0; flush = 1'b0;
        word_ready = 1'b0; ovf_clr = 1'b0;
        m_lvl = 0; m_ovf = 1'b0; m_cnt = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        cyc();
        n_total++;
        if ({obs_status, word_data} !== {16'b0_0_1_0000_0_00000000, 32'h0})
            $display("FAIL reset_state: got status=%b data=%h, expected status=0010000000000000 data=0",
                     obs_status, word_data);
        else
            n_pass++;
    endtask

    task automatic test_single();
        push_words(32'hDEADBEEF, 1);
        n_total++;
        if (word_valid !== 1'b1 || word_data !== 32'hDEADBEEF || level !== 4'd1)
            $display("FAIL single_latency: got valid=%b data=%h level=%0d, expected 1 deadbeef 1",
                     word_valid, word_data, level);
        else
            n_pass++;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_total++;
            if (word_valid !== 1'b1 || word_data !== 32'hDEADBEEF)
                $display("FAIL single_hold: cycle %0d got valid=%b data=%h, expected 1 deadbeef",
                         i, word_valid, word_data);
            else
                n_pass++;
        end
        word_ready = 1'b1;
        cyc();
        word_ready = 1'b0;
        n_total++;
        if (empty !== 1'b1 || obs_status !== m_status())
            $display("FAIL single_pop: got empty=%b status=%b, expected empty=1 status=%b",
                     empty, obs_status, m_status());
        else
            n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int pass = 0; pass < 2; pass++) begin
            push_words(pass == 0 ? 32'h1 : 32'h11, DEPTH);
            n_total++;
            if (full !== 1'b1 || obs_status !== m_status())
                $display("FAIL fill_full: pass %0d got full=%b status=%b, expected full=1 status=%b",
                         pass, full, obs_status, m_status());
            else
                n_pass++;
            drain("fill");
        end
    endtask

    task automatic test_drop();
        push_words(32'hA0, DEPTH);
        push_words(32'hBAD, 1);
        n_total++;
`ifdef UART_TXQ_OVF_EN
        if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd1)
`else
        if (level !== 4'd8 || overflow !== 1'b0 || drop_count !== 8'd0)
`endif
            $display("FAIL drop_one: got level=%0d ovf=%b cnt=%0d", level, overflow, drop_count);
        else
            n_pass++;
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        n_total++;
        if (overflow !== 1'b0 || drop_count !== 8'd0 || obs_status !== m_status())
            $display("FAIL drop_clear: got ovf=%b cnt=%0d status=%b, expected 0 0 %b",
                     overflow, drop_count, obs_status, m_status());
        else
            n_pass++;
        push_words(32'hB00, 260);
        n_total++;
`ifdef UART_TXQ_OVF_EN
        if (drop_count !== 8'd255 || overflow !== 1'b1)
`else
        if (drop_count !== 8'd0 || overflow !== 1'b0)
`endif
            $display("FAIL drop_saturate: got ovf=%b cnt=%0d", overflow, drop_count);
        else
            n_pass++;
        memwrite = 1'b1; writedata = 32'hC0C; ovf_clr = 1'b1;
        cyc();
        memwrite = 1'b0; ovf_clr = 1'b0;
        n_total++;
`ifdef UART_TXQ_OVF_EN
        if (drop_count !== 8'd1 || overflow !== 1'b1 || obs_status !== m_status())
`else
        if (drop_count !== 8'd0 || overflow !== 1'b0 || obs_status !== m_status())
`endif
            $display("FAIL drop_clr_race: got ovf=%b cnt=%0d status=%b, model %b",
                     overflow, drop_count, obs_status, m_status());
        else
            n_pass++;
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
    endtask

    task automatic test_full_pushpop();
        memwrite = 1'b1; writedata = 32'h99; word_ready = 1'b1;
        cyc();
        memwrite = 1'b0; word_ready = 1'b0;
        n_total++;
        if (level !== 4'd8 || full !== 1'b1 || drop_count !== 8'd0 || obs_status !== m_status())
            $display("FAIL full_pushpop: got level=%0d full=%b cnt=%0d, expected 8 1 0",
                     level, full, drop_count);
        else
            n_pass++;
        n_total++;
        if (sb.size() != DEPTH || sb[DEPTH-1] !== 32'h99)
            $display("FAIL full_pushpop_order: scoreboard tail=%h size=%0d, expected 00000099 8",
                     sb[sb.size()-1], sb.size());
        else
            n_pass++;
        drain("pushpop");
    endtask

    task automatic test_flush();
        push_words(32'h30, 3);
        memwrite = 1'b1; writedata = 32'h55; flush = 1'b1;
        cyc();
        memwrite = 1'b0; flush = 1'b0;
        n_total++;
        if (level !== 4'd0 || empty !== 1'b1 || obs_status !== m_status())
            $display("FAIL flush_clear: got level=%0d empty=%b status=%b, expected 0 1 %b",
                     level, empty, obs_status, m_status());
        else
            n_pass++;
        push_words(32'h77, 1);
        n_total++;
        if (word_data !== 32'h77 || level !== 4'd1)
            $display("FAIL flush_no_stale: got data=%h level=%0d, expected 00000077 1", word_data, level);
        else
            n_pass++;
        push_words(32'h80, DEPTH - 1);
        memwrite = 1'b1; writedata = 32'h56; flush = 1'b1;
        cyc();
        memwrite = 1'b0; flush = 1'b0;
        n_total++;
        if (drop_count !== 8'd0 || overflow !== 1'b0 || empty !== 1'b1 || obs_status !== m_status())
            $display("FAIL flush_full_nodrop: got ovf=%b cnt=%0d empty=%b, expected 0 0 1",
                     overflow, drop_count, empty);
        else
            n_pass++;
    endtask

    task automatic test_async_reset();
        push_words(32'hE0, 4);
        @(posedge clk);
        #2 reset_n = 1'b0;
        sb.delete();
        m_lvl = 0; m_ovf = 1'b0; m_cnt = 0;
        #1;
        n_total++;
        if ({obs_status, word_data} !== {16'b0_0_1_0000_0_00000000, 32'h0})
            $display("FAIL async_reset: got status=%b data=%h, expected status=0010000000000000 data=0",
                     obs_status, word_data);
        else
            n_pass++;
        @(posedge clk);
        #1 reset_n = 1'b1;
        word_ready = 1'b1;
        repeat (3) cyc();
        word_ready = 1'b0;
        n_total++;
        if (word_valid !== 1'b0 || obs_status !== m_status() || word_data !== 32'h0)
            $display("FAIL reset_no_stale: got valid=%b status=%b data=%h, expected 0 %b 0",
                     word_valid, obs_status, word_data, m_status());
        else
            n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_fill_drain();
        test_drop();
        test_full_pushpop();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_word_queue.md
# uart_tx_word_queue

Word-wide FIFO between the CPU store path and the UART transmit parser. Captures every 32-bit `memwrite` to the UART address, buffers up to `DEPTH` words, and presents them one at a time to the parser over a valid/ready handshake. The CPU can therefore issue back-to-back stores without waiting for serial transmission to finish. It exposes full/empty/level status for CPU polling, plus optional overflow accounting.

## Interface
- `DEPTH`, 8, number of 32-bit entries; power of two, ≥ 2
- `DATA_W`, 32, word width; taken from the shared package constant
- `clk`  in  1  sole clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `memwrite`  in  1  CPU store strobe, already address-decoded; one word per high cycle
- `writedata`  in  DATA_W  CPU store data
- `flush`  in  1  synchronous queue clear
- `word_valid`  out  1  head entry available to parser
- `word_data`  out  DATA_W  head entry
- `word_ready`  in  1  parser accepts head; transfer = `word_valid && word_ready`
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `level`  out  $clog2(DEPTH)+1  current entry count
- `overflow`  out  1  sticky drop flag (macro-dependent)
- `ovf_clr`  in  1  clears `overflow` and `drop_count`
- `drop_count`  out  8  saturating count of dropped writes (macro-dependent)

## Operation
- Storage: circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 → 0. `level` is a separate counter, not derived from the pointers.
- Push: `memwrite && (!full || pop)` writes `writedata` at the write pointer and advances it.
- Pop: `word_valid && word_ready` advances the read pointer.
- `level` update: +1 on push-only, −1 on pop-only, unchanged on push+pop.
- Show-ahead output: `word_valid = !empty`; `word_data = mem[rd_ptr]`. `word_data` holds its value while `word_valid && !word_ready`.
- Full with simultaneous push and pop: both take effect, and `level` stays DEPTH.
- Empty with `memwrite`: the word is stored; no same-cycle bypass to `word_data`.
- Drop: `memwrite && full && !pop` discards the word. The queue state is unchanged.
- Flush:
  - Pointers and `level` go to 0 next cycle.
  - A same-cycle push or pop is ignored.
  - A push discarded by flush is not counted as a drop.
  - Overflow state is untouched.
- `word_ready` while empty has no effect.

## Timing
- Reset values: `word_valid` 0, `full` 0, `empty` 1, `level` 0, `overflow` 0, `drop_count` 0, pointers 0. `word_data` is don't-care but is driven with zeros from reset-cleared storage.
- Reset mid-operation discards all queued words immediately (asynchronous).
- Latency: a push in cycle N gives `word_valid` = 1 with that word in cycle N+1 when the queue was empty.
- A pop in cycle N presents the next entry (or `word_valid` = 0) in cycle N+1.
- `full`, `empty` and `level` are registered and reflect the state after the previous edge.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- Macro: `UART_TXQ_OVF_EN`.
- Defined:
  - Each drop sets `overflow` and increments `drop_count`, which saturates at 255.
  - `ovf_clr` clears both next cycle. A simultaneous drop wins: `overflow` = 1 and `drop_count` = 1.
- Undefined:
  - `overflow` tied 0, `drop_count` tied 0, `ovf_clr` ignored.
  - Drops still occur silently.
- Ports are present in both builds.

## Structure
- Package `uart_txq_pkg`: `DATA_W` constant (32), drop-counter width (8), and a `txq_status_t` packed struct {full, empty, overflow, level} for CPU status readback.
- One sub-module, `uart_txq_ram`:
  - DEPTH×DATA_W array with a synchronous write port and an asynchronous read port.
  - Reset clears the array contents.
- Pointer, level and overflow logic live in the top module.

## Test plan
- Reset, then single write 0xDEADBEEF with `word_ready` = 0 → next cycle `word_valid` = 1, `word_data` = 0xDEADBEEF, `level` = 1; data held stable for 5 cycles; pulse `word_ready` → `empty` = 1 next cycle.
- Write 8 words 0x00000001..0x00000008 back-to-back (DEPTH 8), then drain with `word_ready` = 1 → `full` = 1 after the 8th push; words emerge in order 1..8; pointers wrap cleanly over a second fill of 0x11..0x18.
- Queue full, ninth write 0xBAD with no pop → word dropped, `level` stays 8, `overflow` = 1, `drop_count` = 1 (macro on) or both 0 (macro off); `ovf_clr` → both 0.
- Queue full, simultaneous `memwrite` 0x99 and pop → no drop, `level` = 8, 0x99 emerges last.
- Three words queued, `flush` asserted with concurrent `memwrite` 0x55 → `level` = 0, `empty` = 1, 0x55 absent, `drop_count` unchanged.
- Four words queued, `reset_n` pulsed low mid-cycle → outputs return to reset values asynchronously, and no stale word appears after release.
